// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MEM-stage data memory responder:
//   - default data/address widths used by the interface and the responder
//   - width of the wait-cycle counter (LATENCY is limited to 1..15)
//   - responder FSM state encoding
//   - helper that converts a LATENCY value into the counter preload
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int DATA_WIDTH_DEF    = 32;
   localparam int ADDRESS_WIDTH_DEF = 32;

   // Four bits hold any preload up to LATENCY-1 = 14.
   localparam int LAT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   // The counter is loaded with LATENCY-1 so that it reaches zero on the
   // last wait cycle; the DONE transition happens on that same edge.
   function automatic logic [LAT_CNT_W-1:0] lat_preload(input int latency);
      return LAT_CNT_W'(latency - 1);
   endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// -----------------------------------------------------------------------------
// data_memory_responder_if
// Bundles the MEM-stage request/response signals between the pipeline
// (master) and the data memory responder (slave).
//   i_MemReqM     pipeline -> responder  access request
//   i_MemWriteM   pipeline -> responder  1 = store, 0 = load
//   i_ALUOutM     pipeline -> responder  byte address
//   i_WriteDataM  pipeline -> responder  store data
//   o_ReadDataM   responder -> pipeline  load data (valid with o_RespValidM)
//   o_StallM      responder -> pipeline  freeze IF/ID/EX/MEM registers
//   o_RespValidM  responder -> pipeline  access completes this cycle
//   o_MisalignM   responder -> pipeline  misaligned access flag
// Parameters: DATA_WIDTH, ADDRESS_WIDTH.
// -----------------------------------------------------------------------------
interface data_memory_responder_if
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
);

   logic                     i_MemReqM;
   logic                     i_MemWriteM;
   logic [ADDRESS_WIDTH-1:0] i_ALUOutM;
   logic [DATA_WIDTH-1:0]    i_WriteDataM;
   logic [DATA_WIDTH-1:0]    o_ReadDataM;
   logic                     o_StallM;
   logic                     o_RespValidM;
   logic                     o_MisalignM;

   modport master (
      output i_MemReqM,
      output i_MemWriteM,
      output i_ALUOutM,
      output i_WriteDataM,
      input  o_ReadDataM,
      input  o_StallM,
      input  o_RespValidM,
      input  o_MisalignM
   );

   modport slave (
      input  i_MemReqM,
      input  i_MemWriteM,
      input  i_ALUOutM,
      input  i_WriteDataM,
      output o_ReadDataM,
      output o_StallM,
      output o_RespValidM,
      output o_MisalignM
   );

endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word-addressed storage for the data memory responder.
// Synchronous write, registered read. The storage itself is never reset;
// only the read-data register is cleared by reset.
// Ports:
//   i_CLK   clock, rising edge
//   i_RST   asynchronous active-low reset (read register only)
//   we      write enable
//   re      read enable (loads rdata on the next edge)
//   addr    word index
//   wdata   write data
//   rdata   registered read data, holds when re = 0
// Parameters: DATA_WIDTH, MEM_DEPTH, IDX_W.
// -----------------------------------------------------------------------------
module dmem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 256,
   parameter int IDX_W      = 8
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic                  we,
   input  logic                  re,
   input  logic [IDX_W-1:0]      addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_p1;

   // Write port: storage carries no reset so it can map onto RAM.
   always_ff @(posedge i_CLK) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Read port: registered, holds its value between loads.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         rdata_p1 <= '0;
      end else if (re) begin
         rdata_p1 <= mem[addr];
      end
   end

   assign rdata = rdata_p1;

endmodule

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
// Fixed-latency data memory for the MEM stage of a pipelined MIPS core.
// A request accepted in IDLE is captured, waits LATENCY cycles in WAIT while
// the pipeline is stalled, then completes in DONE for one cycle, where
// o_RespValidM is asserted (and o_ReadDataM carries load data).
// Ports:
//   i_CLK  clock, rising edge
//   i_RST  asynchronous active-low reset
//   bus    data_memory_responder_if.slave (request/response signals)
// Parameters: DATA_WIDTH, ADDRESS_WIDTH, MEM_DEPTH (power of 2),
//             LATENCY (1..15).
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses.
// Such a request skips WAIT, suppresses the store, leaves o_ReadDataM
// unchanged and raises o_MisalignM together with o_RespValidM in DONE.
// Without the macro o_MisalignM is tied low and every access proceeds,
// with address bits [1:0] ignored.
// -----------------------------------------------------------------------------
module data_memory_responder
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
   parameter int MEM_DEPTH     = 256,
   parameter int LATENCY       = 2
) (
   input  logic                   i_CLK,
   input  logic                   i_RST,
   data_memory_responder_if.slave bus
);

   localparam int IDX_W = $clog2(MEM_DEPTH);

   dmem_state_t           state;
   logic [LAT_CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]      addr_p0;
   logic                  wr_p0;
   logic [DATA_WIDTH-1:0] wdata_p0;

   logic                  misaligned;
   logic                  access_fire;
   logic                  arr_we;
   logic                  arr_re;
   logic [DATA_WIDTH-1:0] arr_rdata;

   // Only the word-index bits of the address select storage; the rest wrap.
   logic                  unused_addr_bits;
   assign unused_addr_bits = ^bus.i_ALUOutM;

`ifdef DMEM_ALIGN_CHECK_EN
   logic mis_p0;

   assign misaligned = (bus.i_ALUOutM[1:0] != 2'b00);

   // Set on acceptance of a misaligned request, cleared when DONE retires it.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         mis_p0 <= 1'b0;
      end else if (state == IDLE && bus.i_MemReqM) begin
         mis_p0 <= misaligned;
      end else if (state == DONE) begin
         mis_p0 <= 1'b0;
      end
   end

   assign bus.o_MisalignM = mis_p0;
`else
   assign misaligned      = 1'b0;
   assign bus.o_MisalignM = 1'b0;
`endif

   // ---- stage p0: request capture and wait sequencing ----
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         state    <= IDLE;
         cnt      <= '0;
         addr_p0  <= '0;
         wr_p0    <= 1'b0;
         wdata_p0 <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_MemReqM) begin
                  addr_p0  <= bus.i_ALUOutM[IDX_W+1:2];
                  wr_p0    <= bus.i_MemWriteM;
                  wdata_p0 <= bus.i_WriteDataM;
                  if (misaligned) begin
                     cnt   <= '0;
                     state <= DONE;
                  end else begin
                     cnt   <= lat_preload(LATENCY);
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               // The instruction that was just served may still be
               // presenting i_MemReqM; it is not re-accepted here.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ---- stage p1: array access on the edge that enters DONE ----
   // Gated by state, so an asynchronous reset during WAIT drops a pending
   // store before it can reach the array.
   assign access_fire = (state == WAIT) && (cnt == '0);
   assign arr_we      = access_fire &&  wr_p0;
   assign arr_re      = access_fire && !wr_p0;

   dmem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .IDX_W      (IDX_W)
   ) u_dmem_array (
      .i_CLK (i_CLK),
      .i_RST (i_RST),
      .we    (arr_we),
      .re    (arr_re),
      .addr  (addr_p0),
      .wdata (wdata_p0),
      .rdata (arr_rdata)
   );

   // Stall rises combinationally in the request cycle so the pipeline
   // freezes before the instruction can leave MEM.
   assign bus.o_StallM     = ((state == IDLE) && bus.i_MemReqM) || (state == WAIT);
   assign bus.o_RespValidM = (state == DONE);
   assign bus.o_ReadDataM  = arr_rdata;

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data word width.
REQ-002 Parameter ADDRESS_WIDTH, default 32: byte address width.
REQ-003 Parameter MEM_DEPTH, default 256: number of words, power of 2.
REQ-004 Parameter LATENCY, default 2: wait cycles per access, legal range 1..15.
REQ-005 One clock; reset is asynchronous and active-low: i_CLK, i_RST.
REQ-006 i_CLK  input  1  clock, rising edge.
REQ-007 i_RST  input  1  asynchronous active-low reset.
REQ-008 i_MemReqM  input  1  MEM-stage access request (load or store).
REQ-009 i_MemWriteM  input  1  1 = store, 0 = load; sampled with i_MemReqM.
REQ-010 i_ALUOutM  input  ADDRESS_WIDTH  byte address.
REQ-011 i_WriteDataM  input  DATA_WIDTH  store data.
REQ-012 o_ReadDataM  output  DATA_WIDTH  load data, valid while o_RespValidM=1.
REQ-013 o_StallM  output  1  freeze IF/ID/EX/MEM pipeline registers.
REQ-014 o_RespValidM  output  1  access completes this cycle.
REQ-015 o_MisalignM  output  1  misaligned access flag (macro only, REQ-035).

Function
REQ-016 FSM states: IDLE, WAIT, DONE.
REQ-017 IDLE, i_MemReqM=1: o_StallM=1 combinationally; capture address, write flag, write data; counter <= LATENCY-1; next WAIT.
REQ-018 IDLE, i_MemReqM=0: o_StallM=0, stay IDLE.
REQ-019 WAIT: o_StallM=1; counter decrements each cycle; at counter=0 next DONE.
REQ-020 Entry into DONE (same edge): store writes captured data to array; load registers array word into o_ReadDataM.
REQ-021 DONE: o_StallM=0, o_RespValidM=1 for exactly one cycle; next IDLE unconditionally.
REQ-022 i_MemReqM in DONE is ignored (same instruction still present); a new request is accepted only in IDLE.
REQ-023 Latency: request cycle T0 to response cycle T0+LATENCY+1; o_StallM high T0..T0+LATENCY.
REQ-024 Inputs after capture are don't-care; only captured values are used.
REQ-025 Word index = address[log2(MEM_DEPTH)+1:2]; upper bits ignored (address wraps modulo MEM_DEPTH*4).
REQ-026 Address bits [1:0] ignored for indexing.
REQ-027 o_ReadDataM holds its last value outside DONE; a store leaves o_ReadDataM unchanged.
REQ-028 Store followed by load of same word returns the stored data.

Reset
REQ-029 i_RST=0 forces state IDLE, counter 0, captured registers 0 immediately, independent of i_CLK.
REQ-030 Reset values: o_ReadDataM=0, o_StallM=0, o_RespValidM=0, o_MisalignM=0.
REQ-031 Reset in WAIT aborts access; pending store is not written.
REQ-032 Memory array contents are not reset.

Configuration
REQ-033 Macro DMEM_ALIGN_CHECK_EN selects alignment checking.
REQ-034 Undefined: o_MisalignM tied 0; all accesses proceed.
REQ-035 Defined: request in IDLE with address[1:0]!=0 goes directly to DONE (no WAIT, o_StallM=1 in T0 only), store suppressed, o_ReadDataM unchanged, o_MisalignM=1 with o_RespValidM=1 in DONE.

Structure
REQ-036 Shared package mips_pkg holds FSM state enum, DATA_WIDTH/ADDRESS_WIDTH defaults and latency counter width constant.
REQ-037 Storage in sub-module dmem_array (synchronous write, registered read); FSM and capture in top.

Verification
REQ-038 Reset, then store 0xDEADBEEF to 0x10, LATENCY=2 -> o_StallM high 3 cycles, o_RespValidM pulse cycle 4, array[4]=0xDEADBEEF.
REQ-039 Load 0x10 after REQ-038 -> o_ReadDataM=0xDEADBEEF with o_RespValidM=1 at T0+3.
REQ-040 Store 0x12345678 to 0x410 (MEM_DEPTH=256) then load 0x10 -> 0x12345678 (wrap).
REQ-041 i_RST low during WAIT of store 0xCAFEF00D to 0x20 -> outputs 0 at once; later load 0x20 does not return 0xCAFEF00D.
REQ-042 Back-to-back loads held on i_MemReqM -> request during DONE ignored; second access starts next IDLE cycle, one response per access.
REQ-043 Macro defined, load 0x13 -> o_MisalignM=1 and o_RespValidM=1 at T0+1, no array change; macro undefined -> normal access to word 4.
